// File: rtl/vram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : vram_arbiter_if
// Description : Bundle of the scan, CPU, fill-control and RAM signals that
//               surround the VRAM arbiter.
//               slave  - the arbiter's view.
//               master - the environment's view: scan client, CPU, fill
//                        control and the single-port RAM.
//   Scan : vga_active, vga_addr[8:0] -> vga_data[31:0]
//   CPU  : cpu_req, cpu_we, cpu_addr[8:0], cpu_wdata[31:0]
//          -> cpu_ack, cpu_rdata[31:0]
//   Fill : clr_start, clr_color[31:0] -> clr_busy
//   RAM  : mem_addr[8:0], mem_we, mem_wdata[31:0] <- mem_rdata[31:0]
// Revision    : 1.0 - initial release
// ============================================================================
interface vram_arbiter_if;
  logic        vga_active;
  logic [8:0]  vga_addr;
  logic [31:0] vga_data;

  logic        cpu_req;
  logic        cpu_we;
  logic [8:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;

  logic        clr_start;
  logic [31:0] clr_color;
  logic        clr_busy;

  logic [8:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  vga_active, vga_addr,
    output vga_data,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  clr_start, clr_color,
    output clr_busy,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output vga_active, vga_addr,
    input  vga_data,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output clr_start, clr_color,
    input  clr_busy,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vram_arbiter
// Description : Shares one single-port synchronous video RAM between the
//               display scan port, a hardware fill engine and a CPU port.
//               One grant per cycle, fixed priority scan > fill > CPU.
//               RAM read data returns one cycle after the grant and is
//               steered by a registered last-grant tag.
// Ports       : clk   - system/pixel clock, rising edge
//               reset - asynchronous, active-high
//               bus   - vram_arbiter_if.slave (scan, CPU, fill, RAM signals)
// Parameters  : TILES - number of valid video words (1..512)
// Revision    : 1.0 - initial release
// ============================================================================
module vram_arbiter #(
  parameter int TILES = 300
) (
  input  wire logic     clk,
  input  wire logic     reset,
  vram_arbiter_if.slave bus
);

  localparam logic [9:0] c_TILES = 10'(TILES);
  localparam logic [8:0] c_LAST  = 9'(TILES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CLR  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VGA  = 2'd1,
    TAG_CLR  = 2'd2,
    TAG_CPU  = 2'd3
  } tag_t;

  state_t      r_state;
  logic [8:0]  r_count;
  logic [31:0] r_color;
  tag_t        r_tag;
  logic        r_cpu_oob;   // granted CPU access was out of range
  logic        r_cpu_we;    // granted CPU access was a write
  logic        r_cpu_ack;
  logic        r_clr_busy;
  logic [31:0] r_vga_data;
  logic [31:0] r_cpu_rdata;

  logic        w_grant_vga;
  logic        w_grant_clr;
  logic        w_grant_cpu;
  logic        w_cpu_oob;
  logic [31:0] w_vga_data;
  logic [31:0] w_cpu_rdata;

  // Fixed priority. The CPU is held off in its own ack cycle so that a
  // request still asserted there is only seen as a new one a cycle later.
  assign w_grant_vga = bus.vga_active;
  assign w_grant_clr = !bus.vga_active && (r_state == CLR);
  assign w_grant_cpu = !bus.vga_active && (r_state != CLR) &&
                       bus.cpu_req && !r_cpu_ack;
  assign w_cpu_oob   = ({1'b0, bus.cpu_addr} >= c_TILES);

  always_comb begin
    bus.mem_addr  = 9'd0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = 32'd0;
    if (w_grant_vga) begin
      bus.mem_addr = bus.vga_addr;
    end else if (w_grant_clr) begin
      bus.mem_addr  = r_count;
      bus.mem_we    = 1'b1;
      bus.mem_wdata = r_color;
    end else if (w_grant_cpu) begin
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_we    = bus.cpu_we && !w_cpu_oob;
      bus.mem_wdata = bus.cpu_wdata;
    end
  end

  // RAM data arrives in the cycle after the grant, so the outputs pass it
  // straight through in that cycle and the hold registers keep it after.
  always_comb begin
    w_vga_data = r_vga_data;
    if (r_tag == TAG_VGA) begin
      w_vga_data = bus.mem_rdata;
    end
  end

  always_comb begin
    w_cpu_rdata = r_cpu_rdata;
    if (r_tag == TAG_CPU) begin
      if (r_cpu_oob) begin
        w_cpu_rdata = 32'd0;
      end else if (!r_cpu_we) begin
        w_cpu_rdata = bus.mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_count     <= 9'd0;
      r_color     <= 32'd0;
      r_tag       <= TAG_NONE;
      r_cpu_oob   <= 1'b0;
      r_cpu_we    <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_clr_busy  <= 1'b0;
      r_vga_data  <= 32'd0;
      r_cpu_rdata <= 32'd0;
    end else begin
      r_vga_data  <= w_vga_data;
      r_cpu_rdata <= w_cpu_rdata;
      r_cpu_ack   <= w_grant_cpu;
      r_cpu_oob   <= w_cpu_oob;
      r_cpu_we    <= bus.cpu_we;

      if (w_grant_vga) begin
        r_tag <= TAG_VGA;
      end else if (w_grant_clr) begin
        r_tag <= TAG_CLR;
      end else if (w_grant_cpu) begin
        r_tag <= TAG_CPU;
      end else begin
        r_tag <= TAG_NONE;
      end

      case (r_state)
        IDLE: begin
          if (bus.clr_start) begin
            r_state    <= CLR;
            r_count    <= 9'd0;
            r_color    <= bus.clr_color;
            r_clr_busy <= 1'b1;
          end
        end
        CLR: begin
          // The counter only moves on fill grants, so scan traffic stalls
          // the fill without skipping words. clr_start is ignored here.
          if (w_grant_clr) begin
            if (r_count == c_LAST) begin
              r_state    <= IDLE;
              r_count    <= 9'd0;
              r_clr_busy <= 1'b0;
            end else begin
              r_count <= r_count + 9'd1;
            end
          end
        end
        default: begin
          r_state    <= IDLE;
          r_clr_busy <= 1'b0;
        end
      endcase
    end
  end

  assign bus.vga_data  = w_vga_data;
  assign bus.cpu_rdata = w_cpu_rdata;
  assign bus.cpu_ack   = r_cpu_ack;
  assign bus.clr_busy  = r_clr_busy;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_arbiter
// Description : Directed self-checking bench for vram_arbiter with a
//               behavioural single-port synchronous RAM (512 x 32).
//               RAM words start as 0xDEAD0000 | address.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  vram_arbiter_if bus ();

  vram_arbiter #(.TILES(300)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] ram [0:511];

  initial begin
    for (int a = 0; a < 512; a++) ram[a] = 32'hDEAD0000 | 32'(a);
  end

  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow #1 later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int busy_cycles;
  int saw_ack;
  int bad;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    bus.vga_active = 1'b0; bus.vga_addr  = 9'd0;
    bus.cpu_req    = 1'b0; bus.cpu_we    = 1'b0;
    bus.cpu_addr   = 9'd0; bus.cpu_wdata = 32'd0;
    bus.clr_start  = 1'b0; bus.clr_color = 32'd0;
    bus.mem_rdata  = 32'd0;
    repeat (3) @(posedge clk);
    #3;
    check("rst_vga_data",  bus.vga_data,  32'd0);
    check("rst_cpu_ack",   32'(bus.cpu_ack),  32'd0);
    check("rst_clr_busy",  32'(bus.clr_busy), 32'd0);
    check("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    check("rst_mem_we",    32'(bus.mem_we),   32'd0);
    check("rst_mem_addr",  32'(bus.mem_addr), 32'd0);
    reset = 1'b0;

    // CPU write 0xAB to word 5, then read it back
    tick();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 9'd5; bus.cpu_wdata = 32'hAB;
    #1;
    check("wr_grant_addr", 32'(bus.mem_addr), 32'd5);
    check("wr_grant_we",   32'(bus.mem_we),   32'd1);
    check("wr_grant_data", bus.mem_wdata,     32'hAB);
    check("wr_no_early_ack", 32'(bus.cpu_ack), 32'd0);
    tick(); #1;
    check("wr_ack", 32'(bus.cpu_ack), 32'd1);
    check("turnaround_we",   32'(bus.mem_we),   32'd0);
    check("turnaround_addr", 32'(bus.mem_addr), 32'd0);
    bus.cpu_req = 1'b0;
    tick();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 9'd5;
    #1;
    check("rd_no_ack_in_grant", 32'(bus.cpu_ack), 32'd0);
    check("rd_grant_addr", 32'(bus.mem_addr), 32'd5);
    tick(); #1;
    check("rd_ack", 32'(bus.cpu_ack), 32'd1);
    check("rd_data", bus.cpu_rdata, 32'h000000AB);
    bus.cpu_req = 1'b0;
    tick(); #1;
    check("ack_one_cycle", 32'(bus.cpu_ack), 32'd0);
    check("rd_data_hold", bus.cpu_rdata, 32'h000000AB);

    // Scan blocks the CPU for 10 cycles; scan of word 5 sees the CPU write
    tick();
    bus.vga_active = 1'b1; bus.vga_addr = 9'd5;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 9'd7;
    saw_ack = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.cpu_ack) saw_ack++;
      tick();
    end
    check("scan_after_cpu_write", bus.vga_data, 32'h000000AB);
    bus.vga_active = 1'b0;
    #1;
    check("blocked_no_ack", 32'(saw_ack), 32'd0);
    check("cpu_grant_after_scan", 32'(bus.mem_addr), 32'd7);
    tick(); #1;
    check("ack_after_scan", 32'(bus.cpu_ack), 32'd1);
    check("rd_word7", bus.cpu_rdata, 32'hDEAD0007);
    check("vga_data_hold", bus.vga_data, 32'h000000AB);
    bus.cpu_req = 1'b0;

    // Fill with 0x3F, no scan traffic
    tick();
    bus.clr_start = 1'b1; bus.clr_color = 32'h3F;
    tick();
    bus.clr_start = 1'b0;
    busy_cycles = 0;
    while (bus.clr_busy && busy_cycles < 1000) begin
      busy_cycles++;
      tick();
    end
    check("fill_busy_cycles", 32'(busy_cycles), 32'd300);
    bus.vga_active = 1'b1; bus.vga_addr = 9'd0;
    tick();
    bus.vga_addr = 9'd150; #1;
    check("fill_word0", bus.vga_data, 32'h3F);
    tick();
    bus.vga_addr = 9'd299; #1;
    check("fill_word150", bus.vga_data, 32'h3F);
    tick();
    bus.vga_addr = 9'd300; #1;
    check("fill_word299", bus.vga_data, 32'h3F);
    tick();
    bus.vga_active = 1'b0; #1;
    check("fill_word300_untouched", bus.vga_data, 32'hDEAD012C);

    // Fill with 0x55 while scan toggles every cycle and the CPU waits
    tick();
    bus.clr_start = 1'b1; bus.clr_color = 32'h55;
    tick();
    bus.clr_start = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 9'd10;
    busy_cycles = 0;
    saw_ack = 0;
    while (bus.clr_busy && busy_cycles < 2000) begin
      busy_cycles++;
      bus.vga_active = busy_cycles[0];
      #1;
      if (bus.cpu_ack) saw_ack++;
      tick();
    end
    bus.vga_active = 1'b0;
    #1;
    check("stall_busy_cycles", 32'(busy_cycles), 32'd600);
    check("cpu_held_during_fill", 32'(saw_ack), 32'd0);
    check("cpu_grant_after_fill", 32'(bus.mem_addr), 32'd10);
    tick(); #1;
    check("ack_after_fill", 32'(bus.cpu_ack), 32'd1);
    check("rd_filled_word10", bus.cpu_rdata, 32'h55);
    bus.cpu_req = 1'b0;
    tick();
    bad = 0;
    for (int i = 0; i <= 300; i++) begin
      bus.vga_active = (i < 300);
      bus.vga_addr   = 9'(i);
      #1;
      if (i > 0 && bus.vga_data !== 32'h55) bad++;
      tick();
    end
    bus.vga_active = 1'b0;
    check("stall_fill_no_skip", 32'(bad), 32'd0);

    // Out-of-range CPU accesses
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 9'd310; bus.cpu_wdata = 32'h1234;
    #1;
    check("oob_wr_grant_addr", 32'(bus.mem_addr), 32'd310);
    check("oob_wr_we_forced", 32'(bus.mem_we), 32'd0);
    tick(); #1;
    check("oob_wr_ack", 32'(bus.cpu_ack), 32'd1);
    check("oob_wr_rdata", bus.cpu_rdata, 32'd0);
    bus.cpu_req = 1'b0;
    tick();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0;
    #1;
    check("oob_rd_we", 32'(bus.mem_we), 32'd0);
    tick(); #1;
    check("oob_rd_ack", 32'(bus.cpu_ack), 32'd1);
    check("oob_rd_rdata", bus.cpu_rdata, 32'd0);
    bus.cpu_req = 1'b0;
    tick();
    bus.vga_active = 1'b1; bus.vga_addr = 9'd310;
    tick();
    bus.vga_active = 1'b0; #1;
    check("oob_word_untouched", bus.vga_data, 32'hDEAD0136);

    // Reset between CPU grant and ack drops the ack
    tick();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 9'd5;
    #1;
    reset = 1'b1;
    tick(); #1;
    check("rst_drops_ack", 32'(bus.cpu_ack), 32'd0);
    check("rst_clears_vga_data", bus.vga_data, 32'd0);
    check("rst_clears_cpu_rdata", bus.cpu_rdata, 32'd0);
    reset = 1'b0;
    bus.cpu_req = 1'b0;

    // Reset at fill counter 120 aborts the fill
    tick();
    bus.clr_start = 1'b1; bus.clr_color = 32'hA5;
    tick();
    bus.clr_start = 1'b0;
    repeat (120) tick();
    reset = 1'b1;
    #1;
    check("abort_busy_now", 32'(bus.clr_busy), 32'd0);
    tick(); #1;
    check("abort_busy_next", 32'(bus.clr_busy), 32'd0);
    reset = 1'b0;
    tick();
    bus.vga_active = 1'b1; bus.vga_addr = 9'd119;
    tick();
    bus.vga_addr = 9'd120; #1;
    check("abort_word119", bus.vga_data, 32'hA5);
    tick();
    bus.vga_addr = 9'd0; #1;
    check("abort_word120_kept", bus.vga_data, 32'h55);
    tick();
    bus.vga_active = 1'b0; #1;
    check("abort_word0", bus.vga_data, 32'hA5);
    check("abort_stays_idle", 32'(bus.clr_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
